// File: rtl/irq_ctrl.sv
// Maskable interrupt controller: rising-edge latching, fixed priority (highest index wins),
// single outstanding request tracked from acknowledge to RETI. Optional NMI via IRQ_NMI_EN.
module irq_ctrl #(
  parameter int NUM_IRQ = 14
) (
  input  logic               clk,
  input  logic               rst,
`ifdef IRQ_NMI_EN
  input  logic               nmi,
`endif
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_ie,
  input  logic               gie,
  input  logic               irq_ack,
  input  logic               reti,
  output logic               irq_req,
  output logic [15:0]        irq_vec,
  output logic [NUM_IRQ-1:0] irq_clr,
  output logic               irq_active
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t             r_state, w_state_next;
  logic [NUM_IRQ-1:0] r_irq_q, r_pend, w_pend_next, w_set, w_elig, w_sel_onehot, w_clr;
  logic [3:0]         r_sel, w_win;
  logic               w_any, w_sel_ie, w_take, w_ack;
  logic               w_nmi_pend, w_nmi_sel;
  logic               r_irq_req, r_irq_active;
  logic [15:0]        r_irq_vec;
  logic [NUM_IRQ-1:0] r_irq_clr;

  assign w_set        = irq & ~r_irq_q;
  assign w_elig       = r_pend & irq_ie;
  assign w_any        = |w_elig;
  assign w_sel_onehot = NUM_IRQ'(1) << r_sel;
  assign w_sel_ie     = |(irq_ie & w_sel_onehot);

  // Later (higher) indices overwrite earlier ones, so the highest eligible index wins.
  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_elig[i]) w_win = 4'(i);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_nmi_pend || (gie && w_any)) w_state_next = REQ;
      REQ: begin
        if (irq_ack)                              w_state_next = SERV;
        else if (!w_nmi_sel && (!gie || !w_sel_ie)) w_state_next = IDLE;
      end
      SERV: if (reti) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_take      = (r_state == IDLE) && (w_state_next == REQ);
  assign w_ack       = (r_state == REQ) && irq_ack;
  assign w_clr       = (w_ack && !w_nmi_sel) ? w_sel_onehot : '0;
  // A new edge on the bit being acknowledged keeps it pending.
  assign w_pend_next = (r_pend & ~w_clr) | w_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_irq_q      <= '0;
      r_pend       <= '0;
      r_sel        <= '0;
      r_irq_req    <= 1'b0;
      r_irq_vec    <= 16'h0000;
      r_irq_clr    <= '0;
      r_irq_active <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_irq_q      <= irq;
      r_pend       <= w_pend_next;
      r_irq_req    <= (w_state_next == REQ);
      r_irq_active <= (w_state_next == SERV);
      r_irq_clr    <= w_clr;
      if (w_take) begin
        if (w_nmi_pend) begin
          r_irq_vec <= 16'hFFFC;
        end else begin
          r_sel     <= w_win;
          r_irq_vec <= 16'hFFE0 + {11'b0, w_win, 1'b0};
        end
      end
    end
  end

`ifdef IRQ_NMI_EN
  logic r_nmi_q, r_nmi_pend, r_sel_nmi;

  assign w_nmi_pend = r_nmi_pend;
  assign w_nmi_sel  = r_sel_nmi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nmi_q    <= 1'b0;
      r_nmi_pend <= 1'b0;
      r_sel_nmi  <= 1'b0;
    end else begin
      r_nmi_q    <= nmi;
      r_nmi_pend <= (r_nmi_pend & ~(w_ack & r_sel_nmi)) | (nmi & ~r_nmi_q);
      if (w_take) r_sel_nmi <= r_nmi_pend;
    end
  end
`else
  assign w_nmi_pend = 1'b0;
  assign w_nmi_sel  = 1'b0;
`endif

  assign irq_req    = r_irq_req;
  assign irq_vec    = r_irq_vec;
  assign irq_clr    = r_irq_clr;
  assign irq_active = r_irq_active;

endmodule
